serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on an accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 Port: bin  input  1  borrow-in; captured on an accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse marking a new valid result.
REQ-010 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-012 The block SHALL compute diff/bout bit-serially, LSB first, one bit per clock, using a single full-subtractor cell and a 1-bit borrow register.
REQ-013 Per-bit cell SHALL be: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: on start=1, the block SHALL load a, b into shift registers, bin into the borrow register, clear the bit counter, and enter RUN at that edge.
REQ-016 IDLE with start=0: no state change; outputs hold.
REQ-017 RUN: each edge SHALL shift a and b right by one, shift d into the partial-result register from the MSB end, update borrow, increment counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 the block SHALL load diff with the full partial result, load bout with br_next, and enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then return unconditionally to IDLE.
REQ-020 Latency: done SHALL be high in the cycle after the WIDTH-th edge following the edge that accepted start; next start is accepted no earlier than WIDTH+2 cycles after the previous one.
REQ-021 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); both are registered.
REQ-022 start while in RUN or DONE SHALL be ignored (no restart, no queuing); a, b, bin changes after acceptance SHALL not affect the result.
REQ-023 diff and bout SHALL hold the last completed result from DONE until the next completion, including throughout RUN.
REQ-024 Wrap-around: results SHALL be modulo 2^WIDTH; underflow is signalled only by bout=1.
REQ-025 WIDTH=1 SHALL behave identically to one full-subtractor evaluated over one RUN cycle.

Reset
REQ-026 On rst_n=0, the block SHALL immediately, independent of clk, enter IDLE and force busy=0, done=0, diff=0, bout=0, counter=0, borrow=0, shift registers=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL occur for it, and diff/bout SHALL read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification (WIDTH=8 unless stated)
REQ-029 a=0x05, b=0x03, bin=0, start pulse -> busy high 8 cycles, done pulse, diff=0x02, bout=0.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-031 WIDTH=1, all 8 combinations of (a,b,bin) from 000 to 111 -> (diff,bout) = 00,11,11,01,10,00,00,11.
REQ-032 Start held high continuously during RUN with changing a/b -> only one operation, result from the operands sampled at acceptance; back-to-back ops spaced WIDTH+2 cycles both complete correctly.
REQ-033 rst_n pulsed low at RUN cycle 4 of a=0xAA, b=0x55 -> busy, done, diff, bout go 0 asynchronously; no done pulse; subsequent op a=0xAA, b=0x55, bin=0 -> diff=0x55, bout=0.
REQ-034 Randomized 1000 ops vs. reference model (a - b - bin) mod 256, bout = (a < b + bin) -> zero mismatches; done count equals accepted-start count.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop produce
// a - b - bin over WIDTH clocks, LSB first, with a busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   part_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               d_c;
    logic               br_next_c;
    logic               last_c;
    logic [WIDTH-1:0]   part_shift_c;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign d_c       = a_sr[0] ^ b_sr[0] ^ br_q;
    assign br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br_q);
    assign last_c    = (cnt_q == LAST_BIT);

    // Partial result fills from the MSB end so bit 0 lands at position 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_part_w1
            assign part_shift_c = d_c;
        end else begin : g_part_wn
            assign part_shift_c = {d_c, part_q[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start)  state_d = S_RUN;
            S_RUN:  if (last_c) state_d = S_DONE;
            S_DONE:             state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    // Operand capture, serial shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            part_q <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br_q  <= bin;
                        cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br_q   <= br_next_c;
                    part_q <= part_shift_c;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        diff <= part_shift_c;
                        bout <= br_next_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == S_RUN);
            done <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a timeline model of the 8-bit instance checked
// every cycle, plus literal expectations and a WIDTH=1 truth-table instance.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic         start1 = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         bin1   = 1'b0;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         bout1;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted start yields busy for W cycles, then one done
    // cycle carrying (a - b - bin) mod 2^W; the next start is allowed W+2 edges later.
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_bout = 1'b0;
    logic [W-1:0] m_diff = '0;
    bit           pending = 1'b0;
    logic [W-1:0] p_diff = '0;
    bit           p_bout = 1'b0;
    int           e = 0;
    int           acc_e = 0;
    int           next_ok = 0;
    int           m_acc = 0;
    int           m_comp = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_diff  = '0;
            m_bout  = 1'b0;
            pending = 1'b0;
            next_ok = 0;
        end else begin
            e++;
            m_done = 1'b0;
            if (pending && e == acc_e + int'(W)) begin
                m_diff  = p_diff;
                m_bout  = p_bout;
                m_done  = 1'b1;
                m_busy  = 1'b0;
                pending = 1'b0;
                m_comp++;
            end
            if (!pending && start && e >= next_ok) begin
                int ext;
                ext     = int'(a) - int'(b) - int'(bin);
                p_diff  = W'(ext);
                p_bout  = (int'(a) < int'(b) + int'(bin));
                pending = 1'b1;
                acc_e   = e;
                next_ok = e + int'(W) + 2;
                m_busy  = 1'b1;
                m_acc++;
            end
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model.
    bit chk_en   = 1'b0;
    int dut_done = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_diff", 32'(diff), 32'(m_diff));
            chk("cyc_bout", 32'(bout), 32'(m_bout));
            if (done) dut_done++;
        end
    end

    // One operation with literal expectations; operands are scrambled right after acceptance.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input logic [W-1:0] ed, input logic eb);
        int lat;
        bit found;
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                found = 1'b1;
                lat   = i;
                break;
            end
            @(negedge clk);
        end
        chk("op_done_seen", 32'(found), 32'd1);
        if (found) begin
            chk("op_latency", 32'(lat), 32'(W));
            chk("op_diff", 32'(diff), 32'(ed));
            chk("op_bout", 32'(bout), 32'(eb));
        end
    endtask

    logic [1:0] w1_exp [8];

    initial begin
        w1_exp = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases; consecutive calls are spaced exactly W+2 edges.
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start held high with operands changing every cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h90; b = 8'h21; bin = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == int'(W)) begin
                chk("held_done", 32'(done), 32'd1);
                chk("held_diff", 32'(diff), 32'h6F);
                chk("held_bout", 32'(bout), 32'd0);
            end
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=1 instance over all (a, b, bin) combinations.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_early_done", 32'(done1), 32'd0);
            @(negedge clk);
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_diff", 32'(diff1), 32'(w1_exp[i][1]));
            chk("w1_bout", 32'(bout1), 32'(w1_exp[i][0]));
            chk("w1_busy_off", 32'(busy1), 32'd0);
            @(negedge clk);
            chk("w1_done_off", 32'(done1), 32'd0);
        end

        // Reset in the middle of a RUN abandons the operation.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);

        // Random traffic with random start spacing and operands churning every cycle.
        begin
            int target;
            target = m_acc + 1000;
            for (int c = 0; c < 20000 && m_acc < target; c++) begin
                @(negedge clk);
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 3) == 0);
            end
            start = 1'b0;
            chk("rand_ops", 32'(m_acc >= target), 32'd1);
        end
        repeat (12) @(negedge clk);
        chk("done_count", 32'(dut_done), 32'(m_comp));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
